// File: rtl/dram_arb_if.sv
// Core-side request/response bus and DRAM port for dram_arbiter.
// slave = arbiter side; master = cores plus DRAM model.
interface dram_arb_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_CORES-1:0]             core_req;
  logic [NUM_CORES-1:0]             core_we;
  logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
  logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]             core_ack;
  logic [DATA_W-1:0]                core_rdata;
  logic                             mem_we;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W-1:0]                mem_wdata;
  logic [DATA_W-1:0]                mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_ack, core_rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input  core_ack, core_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM (1-cycle registered read) among NUM_CORES cores.
// Optional DRAM_ARB_STATS_EN adds per-core saturating grant counters on grant_cnt.
`ifdef DRAM_ARB_STATS_EN
module dram_arb_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module dram_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic              clk,
  input  logic              rst_n,
  dram_arb_if.slave         bus
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0] grant_cnt
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     g;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_CORES-1:0] elig;
  logic [IDX_W-1:0]     pick;
  logic                 found;

  // A core being acked this cycle is masked so its still-high req is not re-granted.
  assign elig = bus.core_req & ~bus.core_ack;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_grant     <= IDX_W'(NUM_CORES - 1);
      g              <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.core_ack   <= '0;
      bus.core_rdata <= '0;
    end else begin
      bus.core_ack <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            g          <= pick;
            last_grant <= pick;
            we_q       <= bus.core_we[pick];
            addr_q     <= bus.core_addr[pick];
            wdata_q    <= bus.core_wdata[pick];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RESP;
        S_RESP: begin
          bus.core_ack[g] <= 1'b1;
          if (!we_q) bus.core_rdata <= bus.mem_rdata;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address/data simply hold between grants; only mem_we qualifies the DRAM access.
  assign bus.mem_we    = (state == S_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

`ifdef DRAM_ARB_STATS_EN
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_stats
    logic inc;
    assign inc = (state == S_RESP) && (g == IDX_W'(i));
    dram_arb_stat_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc),
      .cnt   (grant_cnt[i*16 +: 16])
    );
  end
`endif
endmodule
